uab_clk_div_gen: RTL and testbench

Parametrised multi-channel clock-divider and clock-enable generator with lock indication, running from a single reference clock.
- Produces NUM_CLOCKS phase-aligned divided waveforms plus matching one-cycle clock-enable pulses for fabric logic.
- Divide ratio and phase are reconfigurable per channel at runtime through a valid/ready handshake.
- Sits beside the system PLL; consumes its output clock and its reset.

---
 rtl/uab_clk_div_gen.sv | 166 ++++++++++++++++
 tb/tb_uab_clk_div_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uab_clk_div_gen.sv
// uab_clk_div_gen
//   Multi-channel clock divider / clock-enable generator with lock indication.
//   Every channel counts 0..div-1 from a shared reference clock. After any
//   reconfiguration (or reset) all counters are reloaded with their phase
//   offsets on the same edge, so the channels stay phase-aligned. locked
//   rises once the outputs have run for LOCK_CYCLES cycles after that reload.
//
// Ports
//   refclk     in   reference clock, all logic on the rising edge
//   rst        in   asynchronous active-high reset
//   cfg_valid  in   reconfiguration request
//   cfg_ready  out  request is accepted when cfg_valid & cfg_ready at an edge
//   cfg_chan   in   target channel (values >= NUM_CLOCKS only realign)
//   cfg_div    in   new divide ratio (0 is stored as 1)
//   cfg_phase  in   new phase offset (clamped to div-1)
//   gate_mask  in   per-channel gate, only with UAB_CLKDIV_GATE_EN defined
//   outclk     out  registered divided waveforms
//   ce         out  registered one-cycle clock-enable pulses
//   locked     out  all channels aligned and settled
//
// Optional feature macro: UAB_CLKDIV_GATE_EN (adds gate_mask input).
module uab_clk_div_gen #(
  parameter int unsigned NUM_CLOCKS  = 4,
  parameter int unsigned CH_W        = 2,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DIV_DEFAULT = 2,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CH_W-1:0]       cfg_chan,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic [DIV_W-1:0]      cfg_phase,
`ifdef UAB_CLKDIV_GATE_EN
  input  logic [NUM_CLOCKS-1:0] gate_mask,
`endif
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] ce,
  output logic                  locked
);

  localparam int unsigned      SET_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {ST_ALIGN, ST_SETTLE, ST_LOCKED} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [SET_W-1:0]      r_settle;
  logic [DIV_W-1:0]      r_div   [NUM_CLOCKS];
  logic [DIV_W-1:0]      r_phase [NUM_CLOCKS];
  logic [DIV_W-1:0]      r_cnt   [NUM_CLOCKS];
  logic [NUM_CLOCKS-1:0] r_outclk;
  logic [NUM_CLOCKS-1:0] r_ce;

  logic                  w_accept;
  logic [DIV_W-1:0]      w_cfg_div;
  logic [DIV_W-1:0]      w_cfg_phase;
  logic [DIV_W-1:0]      w_cnt_upd [NUM_CLOCKS];
  logic [DIV_W-1:0]      w_half    [NUM_CLOCKS];
  logic [NUM_CLOCKS-1:0] w_gate;
  logic [NUM_CLOCKS-1:0] w_outclk_next;
  logic [NUM_CLOCKS-1:0] w_ce_next;

  assign w_accept  = cfg_valid && (r_state == ST_LOCKED);
  assign cfg_ready = (r_state == ST_LOCKED);
  assign locked    = (r_state == ST_LOCKED);
  assign outclk    = r_outclk;
  assign ce        = r_ce;

  // Phase is clamped against the sanitised (new) divide ratio.
  assign w_cfg_div   = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
  assign w_cfg_phase = (cfg_phase >= w_cfg_div) ? (w_cfg_div - DIV_W'(1)) : cfg_phase;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) r_state <= ST_ALIGN;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_ALIGN:  w_state_next = ST_SETTLE;
      ST_SETTLE: if (r_settle == SET_LAST) w_state_next = ST_LOCKED;
      ST_LOCKED: if (w_accept) w_state_next = ST_ALIGN;
      default:   w_state_next = ST_ALIGN;
    endcase
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst)                                                r_settle <= '0;
    else if (r_state == ST_ALIGN)                           r_settle <= '0;
    else if (r_state == ST_SETTLE && r_settle != SET_LAST)  r_settle <= r_settle + SET_W'(1);
  end

  // ---------------------------------------------------------- channels
  // In ALIGN the next counter value is the phase reload; otherwise it wraps.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
      w_cnt_upd[i] = '0;
      if (r_state == ST_ALIGN)                       w_cnt_upd[i] = r_phase[i];
      else if (r_cnt[i] == r_div[i] - DIV_W'(1))     w_cnt_upd[i] = '0;
      else                                           w_cnt_upd[i] = r_cnt[i] + DIV_W'(1);
      // ceil(div/2) without needing an extra bit
      w_half[i] = (r_div[i] >> 1) + DIV_W'(r_div[i][0]);
    end
  end

`ifdef UAB_CLKDIV_GATE_EN
  // The gate is resampled only when a counter returns to 0 (or on the
  // realign load, when outputs are already idle), so a period in flight is
  // always completed and gating never shifts the counter phase.
  logic [NUM_CLOCKS-1:0] r_gate;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
      w_gate[i] = r_gate[i];
      if (r_state == ST_ALIGN || w_cnt_upd[i] == '0) w_gate[i] = gate_mask[i];
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) r_gate <= '0;
    else     r_gate <= w_gate;
  end
`else
  assign w_gate = '0;
`endif

  always_comb begin
    w_outclk_next = '0;
    w_ce_next     = '0;
    for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
      if (w_state_next != ST_ALIGN && !w_gate[i]) begin
        w_outclk_next[i] = (w_cnt_upd[i] < w_half[i]);
        w_ce_next[i]     = (w_cnt_upd[i] == '0);
      end
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
        r_div[i]   <= DIV_W'(DIV_DEFAULT);
        r_phase[i] <= '0;
        r_cnt[i]   <= '0;
      end
      r_outclk <= '0;
      r_ce     <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
        r_cnt[i] <= w_cnt_upd[i];
        if (w_accept && cfg_chan == CH_W'(i)) begin
          r_div[i]   <= w_cfg_div;
          r_phase[i] <= w_cfg_phase;
        end
      end
      r_outclk <= w_outclk_next;
      r_ce     <= w_ce_next;
    end
  end

endmodule

// File: tb/tb_uab_clk_div_gen.sv
module tb_uab_clk_div_gen;

  logic       refclk;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_chan;
  logic [7:0] cfg_div;
  logic [7:0] cfg_phase;
  logic [3:0] outclk;
  logic [3:0] ce;
  logic       locked;
`ifdef UAB_CLKDIV_GATE_EN
  logic [3:0] gate_mask;
`endif

  int n_tests;
  int n_fail;

  uab_clk_div_gen #(
    .NUM_CLOCKS (4),
    .CH_W       (2),
    .DIV_W      (8),
    .DIV_DEFAULT(2),
    .LOCK_CYCLES(16)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_div  (cfg_div),
    .cfg_phase(cfg_phase),
`ifdef UAB_CLKDIV_GATE_EN
    .gate_mask(gate_mask),
`endif
    .outclk   (outclk),
    .ce       (ce),
    .locked   (locked)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  // Present a request before the next edge; that edge accepts it.
  task automatic request(input logic [1:0] ch, input logic [7:0] dv, input logic [7:0] ph);
    cfg_chan  = ch;
    cfg_div   = dv;
    cfg_phase = ph;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_v;
    rst = 1'b1;
    repeat (2) tick();
    n_tests++; if (outclk !== 4'h0) begin n_fail++; $display("FAIL reset_outclk got %h exp %h", outclk, 4'h0); end
    n_tests++; if (ce !== 4'h0)     begin n_fail++; $display("FAIL reset_ce got %h exp %h", ce, 4'h0); end
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %b exp 0", locked); end
    n_tests++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", cfg_ready); end
    #3 rst = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      exp_v = (k % 2 == 1) ? 4'hF : 4'h0;
      n_tests++; if (outclk !== exp_v) begin n_fail++; $display("FAIL dflt_outclk k=%0d got %h exp %h", k, outclk, exp_v); end
      n_tests++; if (ce !== exp_v)     begin n_fail++; $display("FAIL dflt_ce k=%0d got %h exp %h", k, ce, exp_v); end
      n_tests++; if (locked !== (k == 17)) begin n_fail++; $display("FAIL dflt_locked k=%0d got %b exp %b", k, locked, (k == 17)); end
    end
    n_tests++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL dflt_ready got %b exp 1", cfg_ready); end
  endtask

  task automatic test_reconfig();
    logic [3:0] eo, ec;
    int c1, co;
    request(2'd1, 8'd5, 8'd2);
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rcfg_locked_t got %b exp 0", locked); end
    n_tests++; if (outclk !== 4'h0) begin n_fail++; $display("FAIL rcfg_outclk_t got %h exp 0", outclk); end
    n_tests++; if (ce !== 4'h0)     begin n_fail++; $display("FAIL rcfg_ce_t got %h exp 0", ce); end
    n_tests++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL rcfg_ready_t got %b exp 0", cfg_ready); end
    for (int k = 1; k <= 17; k++) begin
      tick();
      c1 = (2 + k - 1) % 5;
      co = (k - 1) % 2;
      eo = {co == 0, co == 0, c1 < 3, co == 0};
      ec = {co == 0, co == 0, c1 == 0, co == 0};
      n_tests++; if (outclk !== eo) begin n_fail++; $display("FAIL rcfg_outclk k=%0d got %h exp %h", k, outclk, eo); end
      n_tests++; if (ce !== ec)     begin n_fail++; $display("FAIL rcfg_ce k=%0d got %h exp %h", k, ce, ec); end
      n_tests++; if (locked !== (k == 17)) begin n_fail++; $display("FAIL rcfg_locked k=%0d got %b exp %b", k, locked, (k == 17)); end
    end
  endtask

  task automatic test_sanitise();
    logic [3:0] eo, ec;
    int c1, c3, co;
    // div=0 -> 1: channel 2 constant high
    request(2'd2, 8'd0, 8'd5);
    for (int k = 1; k <= 17; k++) begin
      tick();
      c1 = (2 + k - 1) % 5;
      co = (k - 1) % 2;
      eo = {co == 0, 1'b1, c1 < 3, co == 0};
      ec = {co == 0, 1'b1, c1 == 0, co == 0};
      n_tests++; if (outclk !== eo) begin n_fail++; $display("FAIL div0_outclk k=%0d got %h exp %h", k, outclk, eo); end
      n_tests++; if (ce !== ec)     begin n_fail++; $display("FAIL div0_ce k=%0d got %h exp %h", k, ce, ec); end
    end
    n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL div0_locked got %b exp 1", locked); end
    // phase 7 with div 4 -> stored phase 3
    request(2'd3, 8'd4, 8'd7);
    for (int k = 1; k <= 17; k++) begin
      tick();
      c1 = (2 + k - 1) % 5;
      c3 = (3 + k - 1) % 4;
      co = (k - 1) % 2;
      eo = {c3 < 2, 1'b1, c1 < 3, co == 0};
      ec = {c3 == 0, 1'b1, c1 == 0, co == 0};
      n_tests++; if (outclk !== eo) begin n_fail++; $display("FAIL phclamp_outclk k=%0d got %h exp %h", k, outclk, eo); end
      n_tests++; if (ce !== ec)     begin n_fail++; $display("FAIL phclamp_ce k=%0d got %h exp %h", k, ce, ec); end
    end
    n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL phclamp_locked got %b exp 1", locked); end
  endtask

  task automatic test_stall();
    int c0;
    logic eo, ec;
    request(2'd0, 8'd3, 8'd1);
    for (int k = 1; k <= 17; k++) begin
      if (k > 1) tick();
      else tick();
      c0 = (1 + k - 1) % 3;
      eo = (c0 < 2);
      ec = (c0 == 0);
      n_tests++; if (outclk[0] !== eo) begin n_fail++; $display("FAIL stall_outclk0 k=%0d got %b exp %b", k, outclk[0], eo); end
      n_tests++; if (ce[0] !== ec)     begin n_fail++; $display("FAIL stall_ce0 k=%0d got %b exp %b", k, ce[0], ec); end
      n_tests++; if (cfg_ready !== (k == 17)) begin n_fail++; $display("FAIL stall_ready k=%0d got %b exp %b", k, cfg_ready, (k == 17)); end
      if (k == 1) begin
        cfg_chan  = 2'd0;
        cfg_div   = 8'd6;
        cfg_phase = 8'd0;
        cfg_valid = 1'b1;
      end
    end
    tick();
    cfg_valid = 1'b0;
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL stall_accept got %b exp 0", locked); end
    for (int k = 1; k <= 18; k++) begin
      tick();
      c0 = (k - 1) % 6;
      eo = (c0 < 3);
      ec = (c0 == 0);
      n_tests++; if (outclk[0] !== eo) begin n_fail++; $display("FAIL stall_new_outclk0 k=%0d got %b exp %b", k, outclk[0], eo); end
      n_tests++; if (ce[0] !== ec)     begin n_fail++; $display("FAIL stall_new_ce0 k=%0d got %b exp %b", k, ce[0], ec); end
      n_tests++; if (locked !== (k >= 17)) begin n_fail++; $display("FAIL stall_new_locked k=%0d got %b exp %b", k, locked, (k >= 17)); end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] exp_v;
    request(2'd2, 8'd9, 8'd0);
    repeat (3) tick();
    // ch2 counter is at 2 of 9: still high
    n_tests++; if (outclk[2] !== 1'b1) begin n_fail++; $display("FAIL arst_pre_outclk2 got %b exp 1", outclk[2]); end
    #3 rst = 1'b1;
    #1;
    n_tests++; if (outclk !== 4'h0) begin n_fail++; $display("FAIL arst_outclk got %h exp 0", outclk); end
    n_tests++; if (ce !== 4'h0)     begin n_fail++; $display("FAIL arst_ce got %h exp 0", ce); end
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL arst_locked got %b exp 0", locked); end
    n_tests++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL arst_ready got %b exp 0", cfg_ready); end
    #3 rst = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      exp_v = (k % 2 == 1) ? 4'hF : 4'h0;
      n_tests++; if (outclk !== exp_v) begin n_fail++; $display("FAIL arst_div2_outclk k=%0d got %h exp %h", k, outclk, exp_v); end
      n_tests++; if (ce !== exp_v)     begin n_fail++; $display("FAIL arst_div2_ce k=%0d got %h exp %h", k, ce, exp_v); end
      n_tests++; if (locked !== (k == 17)) begin n_fail++; $display("FAIL arst_locked k=%0d got %b exp %b", k, locked, (k == 17)); end
    end
  endtask

`ifdef UAB_CLKDIV_GATE_EN
  task automatic test_gate();
    int   c;
    logic g, m;
    logic [1:0] eo, ec;
    request(2'd0, 8'd6, 8'd0);
    repeat (17) tick();
    request(2'd1, 8'd6, 8'd0);
    repeat (17) tick();
    n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL gate_prelock got %b exp 1", locked); end
    g = 1'b0;
    for (int k = 18; k <= 40; k++) begin
      m = (k >= 21 && k <= 30);
      gate_mask = {3'b000, m};
      tick();
      c = (k - 1) % 6;
      if (c == 0) g = m;
      eo = {c < 3, (c < 3) && !g};
      ec = {c == 0, (c == 0) && !g};
      n_tests++; if (outclk[1:0] !== eo) begin n_fail++; $display("FAIL gate_outclk k=%0d got %b exp %b", k, outclk[1:0], eo); end
      n_tests++; if (ce[1:0] !== ec)     begin n_fail++; $display("FAIL gate_ce k=%0d got %b exp %b", k, ce[1:0], ec); end
      n_tests++; if (locked !== 1'b1)    begin n_fail++; $display("FAIL gate_locked k=%0d got %b exp 1", k, locked); end
    end
    gate_mask = 4'h0;
  endtask
`endif

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_div   = '0;
    cfg_phase = '0;
`ifdef UAB_CLKDIV_GATE_EN
    gate_mask = '0;
`endif
    test_reset();
    test_reconfig();
    test_sanitise();
    test_stall();
    test_async_reset();
`ifdef UAB_CLKDIV_GATE_EN
    test_gate();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
